// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the branch resolution controller.
package branch_resolve_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
    } fifo_entry_t;

    localparam logic [1:0] SAT_MAX   = 2'd3;
    localparam logic [1:0] SAT_MIN   = 2'd0;
    localparam logic [1:0] CNT_RESET = 2'b01;

    // Saturating two-bit counter step toward the observed outcome.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] r;
        if (taken) begin
            r = (cnt == SAT_MAX) ? cnt : cnt + 2'd1;
        end else begin
            r = (cnt == SAT_MIN) ? cnt : cnt - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_bht_table.sv
// Branch history table: 2^IDX_W saturating counters, combinational lookup,
// update written at the clock edge so a same-cycle lookup sees the old value.
module bht_table
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lk_idx,
    output logic [1:0]       lk_cnt,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int N = 1 << IDX_W;

    logic [1:0] cnt_q [N];
    logic [1:0] cnt_d [N];

    assign lk_cnt = cnt_q[lk_idx];

    // Next counter values: only the addressed entry moves.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = (upd_en && (upd_idx == IDX_W'(i))) ? cnt_next(cnt_q[i], upd_taken) : cnt_q[i];
        end
    end

    // Counter storage with synchronous reset to weakly not-taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= CNT_RESET;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: BHT prediction, in-flight FIFO, mispredict flush.
// Optional statistics counters enabled by defining BRANCH_RESOLVE_STATS_EN.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic                   if_isbranch,
    input  logic [31:0]            if_pc,
    output logic                   pred_taken,
    output logic                   pred_ready,
    input  logic                   ex_valid,
    input  logic                   ex_taken,
    input  logic [31:0]            ex_target,
    output logic                   flush,
    output logic [31:0]            redirect_pc,
`ifdef BRANCH_RESOLVE_STATS_EN
    output logic [31:0]            stat_branches,
    output logic [31:0]            stat_mispred,
`endif
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   underflow_err
);

    localparam int               PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL  = (PTR_W+1)'(DEPTH);

    state_e            state_q, state_d;
    fifo_entry_t       mem_q [DEPTH];
    fifo_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    occ_q, occ_d;
    logic              flush_q, flush_d;
    logic [31:0]       redirect_q, redirect_d;
    logic              underflow_q, underflow_d;

    fifo_entry_t       head_s;
    logic              run_s, pop_s, mis_s, push_s;
    logic [31:0]       correct_pc_s;
    logic [1:0]        lk_cnt_s;

    bht_table #(.IDX_W(IDX_W)) u_bht (
        .clk       (clk),
        .rst       (rst),
        .lk_idx    (if_pc[IDX_W+1:2]),
        .lk_cnt    (lk_cnt_s),
        .upd_en    (pop_s),
        .upd_idx   (head_s.pc[IDX_W+1:2]),
        .upd_taken (ex_taken)
    );

    assign head_s       = mem_q[rd_ptr_q];
    assign run_s        = (state_q == ST_RUN);
    assign pop_s        = ex_valid && run_s && (occ_q != '0);
    assign mis_s        = pop_s && (ex_taken != head_s.pred);
    assign correct_pc_s = ex_taken ? ex_target : head_s.pc + 32'd4;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign pred_taken = if_valid && if_isbranch && (lk_cnt_s >= 2'd2);
    assign pred_ready = run_s && ((occ_q != FULL) || pop_s);
    assign push_s     = if_valid && if_isbranch && pred_ready && !mis_s;

    // Next-state logic for FSM, FIFO and registered outputs.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        if (mis_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = '{pc: if_pc, pred: pred_taken};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end

        case (state_q)
            ST_RUN:   state_d = mis_s ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        flush_d     = mis_s;
        redirect_d  = mis_s ? correct_pc_s : redirect_q;
        underflow_d = underflow_q || (ex_valid && run_s && (occ_q == '0));
    end

    // State registers with synchronous reset abandoning all in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            flush_q     <= 1'b0;
            redirect_q  <= 32'd0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            underflow_q <= underflow_d;
        end
    end

    assign flush         = flush_q;
    assign redirect_pc   = redirect_q;
    assign occupancy     = occ_q;
    assign underflow_err = underflow_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    // Resolved-branch and mispredict counters, free-running with wrap.
    always_comb begin
        stat_branches_d = stat_branches_q + (pop_s ? 32'd1 : 32'd0);
        stat_mispred_d  = stat_mispred_q + (mis_s ? 32'd1 : 32'd0);
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q <= 32'd0;
            stat_mispred_q  <= 32'd0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed scoreboard bench for branch_resolve_ctrl (DEPTH=4, IDX_W=4).
module tb_branch_resolve_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, if_valid, if_isbranch, ex_valid, ex_taken;
    logic [31:0] if_pc, ex_target;
    logic        pred_taken, pred_ready, flush, underflow_err;
    logic [31:0] redirect_pc;
    logic [2:0]  occupancy;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        sb[$];
    logic [1:0]  bht_m [16];
    logic        run_m, flush_m, uf_m;
    logic [31:0] redir_m;
    int          tests = 0;
    int          fails = 0;

    branch_resolve_ctrl #(.DEPTH(4), .IDX_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid      (if_valid),
        .if_isbranch   (if_isbranch),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .pred_ready    (pred_ready),
        .ex_valid      (ex_valid),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
`ifdef BRANCH_RESOLVE_STATS_EN
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred),
`endif
        .occupancy     (occupancy),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
        run_m   = 1'b1;
        flush_m = 1'b0;
        redir_m = 32'd0;
        uf_m    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; if_valid = 1'b0; if_isbranch = 1'b0; if_pc = 32'd0;
        ex_valid = 1'b0; ex_taken = 1'b0; ex_target = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_uf", 32'(underflow_err), 32'd0);
        chk("rst_ready", 32'(pred_ready), 32'd1);
    endtask

    // Lookup without pushing: if_valid drops again before the rising edge.
    task automatic peek(input logic [31:0] pc, input logic exp);
        @(negedge clk);
        if_valid = 1'b1; if_isbranch = 1'b1; if_pc = pc; ex_valid = 1'b0;
        #1;
        chk("peek_pred", 32'(pred_taken), 32'(exp));
        chk("peek_model", 32'(pred_taken), 32'(bht_m[pc[5:2]] >= 2'd2));
        #1;
        if_valid = 1'b0; if_isbranch = 1'b0;
    endtask

    task automatic step(input logic ifv, input logic isb, input logic [31:0] pc,
                        input logic exv, input logic ext, input logic [31:0] tgt);
        logic exp_pred, pop, ready, mis, push;
        ent_t h;
        @(negedge clk);
        if_valid = ifv; if_isbranch = isb; if_pc = pc;
        ex_valid = exv; ex_taken = ext; ex_target = tgt;
        #1;
        exp_pred = ifv && isb && (bht_m[pc[5:2]] >= 2'd2);
        pop      = exv && run_m && (sb.size() > 0);
        ready    = run_m && ((sb.size() < DEPTH) || pop);
        chk("pred_taken", 32'(pred_taken), 32'(exp_pred));
        chk("pred_ready", 32'(pred_ready), 32'(ready));
        mis = 1'b0;
        h   = '{pc: 32'd0, pred: 1'b0};
        if (pop) begin
            h   = sb[0];
            mis = (ext != h.pred);
        end
        push = ifv && isb && ready && !mis;
        if (exv && run_m && (sb.size() == 0)) uf_m = 1'b1;
        @(posedge clk); #1;
        if (pop) begin
            void'(sb.pop_front());
            if (ext) bht_m[h.pc[5:2]] = (bht_m[h.pc[5:2]] == 2'd3) ? 2'd3 : bht_m[h.pc[5:2]] + 2'd1;
            else     bht_m[h.pc[5:2]] = (bht_m[h.pc[5:2]] == 2'd0) ? 2'd0 : bht_m[h.pc[5:2]] - 2'd1;
        end
        if (mis) begin
            sb.delete();
            flush_m = 1'b1;
            redir_m = ext ? tgt : h.pc + 32'd4;
            run_m   = 1'b0;
        end else begin
            flush_m = 1'b0;
            run_m   = 1'b1;
            if (push) sb.push_back('{pc: pc, pred: exp_pred});
        end
        chk("flush", 32'(flush), 32'(flush_m));
        if (flush_m) chk("redirect", redirect_pc, redir_m);
        chk("occupancy", 32'(occupancy), 32'(sb.size()));
        chk("underflow", 32'(underflow_err), 32'(uf_m));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_isbranch = 1'b0; if_pc = 32'd0;
        ex_valid = 1'b0; ex_taken = 1'b0; ex_target = 32'd0;
        model_reset();

        // Training at 0x40
        do_reset();
        peek(32'h40, 1'b0);
        step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h1000);
        idle();
        step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h1000);
        peek(32'h40, 1'b1);

        // Predicted not-taken, resolved taken
        do_reset();
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h200);
        chk("nt_flush", 32'(flush), 32'd1);
        chk("nt_redirect", redirect_pc, 32'h200);
        chk("nt_occ", 32'(occupancy), 32'd0);
        idle();

        // Predicted taken, resolved not-taken
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h200);
        chk("tk_flush", 32'(flush), 32'd1);
        chk("tk_redirect", redirect_pc, 32'h104);
        idle();
        peek(32'h100, 1'b0);

        // Resolve with empty FIFO
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h300);
        chk("uf_flag", 32'(underflow_err), 32'd1);
        chk("uf_noflush", 32'(flush), 32'd0);
        peek(32'h100, 1'b0);
        idle();
        chk("uf_sticky", 32'(underflow_err), 32'd1);

        // Full FIFO, push+pop at full, order check
        do_reset();
        step(1'b1, 1'b1, 32'h60, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h900);
        idle();
        step(1'b1, 1'b1, 32'h60, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h900);
        step(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h48, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h4c, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h50, 1'b0, 1'b0, 32'd0);
        chk("full_occ", 32'(occupancy), 32'd4);
        step(1'b1, 1'b1, 32'h54, 1'b0, 1'b0, 32'd0);
        chk("full_hold", 32'(occupancy), 32'd4);
        step(1'b1, 1'b1, 32'h60, 1'b1, 1'b0, 32'd0);
        chk("full_pushpop", 32'(occupancy), 32'd4);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("order_redirect", redirect_pc, 32'h64);
        idle();

        // Mispredict with simultaneous push, then reset during flush
        step(1'b1, 1'b1, 32'h60, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h70, 1'b1, 1'b0, 32'd0);
        chk("drop_flush", 32'(flush), 32'd1);
        chk("drop_occ", 32'(occupancy), 32'd0);
        do_reset();
        peek(32'h60, 1'b0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
